cp0_irq: RTL and testbench

Parametrised system-control coprocessor (CP0) for the MIPS core: holds Status, Cause, EPC, BadVAddr, Count, Compare and PrId, accepts exceptions and ERET from the pipeline's commit stage, and redirects fetch. Compared with the previous generation it has:
- a configurable number of external interrupt lines, each individually level- or edge-sensitive;
- two software interrupts;
- a prescaled timer;
- defined behaviour for unimplemented registers and nested exceptions.

---
 rtl/cp0_irq.sv | 163 ++++++++++++++++
 tb/tb_cp0_irq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_irq.sv
// MIPS CP0: Status, Cause, EPC, BadVAddr, Count/Compare, PrId, exception/ERET redirect.
// Cause IP map: bits 9:8 software, 14:10 external lines, 15 timer. Timer built with CP0_TIMER_EN.
module cp0_irq #(
   parameter int unsigned NUM_IRQ   = 5,
   parameter logic [4:0]  IRQ_EDGE  = 5'b0,
   parameter int unsigned COUNT_DIV = 1,
   parameter logic [31:0] HANDLER   = 32'hBFC00380,
   parameter logic [31:0] PRID      = 32'hDEADBEEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [4:0]         num,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   input  logic               pipe_busy,
   input  logic               exc_valid,
   input  logic               exc_eret,
   input  logic [4:0]         exc_code,
   input  logic [31:0]        exc_pc,
   input  logic               exc_bd,
   input  logic [31:0]        exc_badvaddr,
   output logic               jump,
   output logic [31:0]        jump_addr,
   output logic               irq_now,
   input  logic [NUM_IRQ-1:0] ext_irq
);

   localparam logic [4:0] LineMask = 5'((6'd1 << NUM_IRQ) - 6'd1);
   localparam logic [4:0] EdgeMask = IRQ_EDGE & LineMask;

   logic [31:0] epc_q, badvaddr_q;
   logic [7:0]  im_q;
   logic        exl_q, ie_q, bd_q;
   logic [4:0]  exccode_q;
   logic [1:0]  sw_ip_q;
   logic [4:0]  irq_q, ep_q, ep_d, ext_pad, hw_ip;
   logic [31:0] count_q, compare_q, sr_rd, cause_rd;
   logic        tip_q, wr, take;

   // Software writes lose to a committing exception/ERET.
   assign wr   = we & ~exc_valid;
   assign take = exc_valid & ~exc_eret & ~exl_q;

   always_comb begin
      ext_pad = '0;
      ext_pad[NUM_IRQ-1:0] = ext_irq;
   end

   // Edge pending: a Cause write with the bit at 0 clears it, but a new edge wins.
   always_comb begin
      ep_d = ep_q;
      if (wr && num == 5'd13) ep_d = ep_q & wdata[14:10];
      ep_d = ep_d | (ext_pad & ~irq_q & EdgeMask);
   end

   assign hw_ip    = (ep_q & EdgeMask) | (irq_q & ~EdgeMask & LineMask);
   assign sr_rd    = {16'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_rd = {bd_q, 15'b0, tip_q, hw_ip, sw_ip_q, 1'b0, exccode_q, 2'b0};

   always_ff @(posedge clk) begin
      if (reset) begin
         epc_q      <= '0;
         badvaddr_q <= '0;
         im_q       <= 8'hFF;
         exl_q      <= 1'b1;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exccode_q  <= '0;
         sw_ip_q    <= '0;
         irq_q      <= '0;
         ep_q       <= '0;
      end else begin
         irq_q <= ext_pad;
         ep_q  <= ep_d;
         if (wr) begin
            unique case (num)
               5'd8:  badvaddr_q <= wdata;
               5'd12: begin
                  im_q  <= wdata[15:8];
                  exl_q <= wdata[1];
                  ie_q  <= wdata[0];
               end
               5'd13: sw_ip_q <= wdata[9:8];
               5'd14: epc_q <= wdata;
               default: ;
            endcase
         end
         if (exc_valid && exc_eret) begin
            exl_q <= 1'b0;
         end else if (take) begin
            epc_q     <= exc_bd ? exc_pc - 32'd4 : exc_pc;
            bd_q      <= exc_bd;
            exccode_q <= exc_code;
            exl_q     <= 1'b1;
            if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr_q <= exc_badvaddr;
         end
      end
   end

`ifdef CP0_TIMER_EN
   localparam logic [31:0] DivLast = 32'(COUNT_DIV - 1);

   logic [31:0] presc_q, count_inc;
   logic        tick, count_wr, compare_wr;

   assign tick       = (presc_q == DivLast);
   assign count_wr   = wr && num == 5'd9;
   assign compare_wr = wr && num == 5'd11;
   assign count_inc  = count_q + 32'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         tip_q     <= 1'b0;
      end else begin
         if (count_wr) begin
            count_q <= wdata;
            presc_q <= '0;
         end else if (tick) begin
            presc_q <= '0;
            count_q <= count_inc;
         end else begin
            presc_q <= presc_q + 32'd1;
         end
         if (compare_wr) compare_q <= wdata;
         // A Compare write clears the pending bit even against a same-cycle match.
         if (compare_wr) begin
            tip_q <= 1'b0;
         end else if (!count_wr && tick && count_inc == compare_q && compare_q != 32'd0) begin
            tip_q <= 1'b1;
         end
      end
   end
`else
   logic unused_div;
   assign unused_div = ^32'(COUNT_DIV);
   assign count_q    = '0;
   assign compare_q  = '0;
   assign tip_q      = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      unique case (num)
         5'd8:    rdata = badvaddr_q;
         5'd9:    rdata = count_q;
         5'd11:   rdata = compare_q;
         5'd12:   rdata = sr_rd;
         5'd13:   rdata = cause_rd;
         5'd14:   rdata = epc_q;
         5'd15:   rdata = PRID;
         default: rdata = '0;
      endcase
   end

   assign irq_now   = ie_q & ~exl_q & ~pipe_busy & (|(cause_rd[15:8] & im_q));
   assign jump      = exc_valid;
   assign jump_addr = !exc_valid ? 32'd0 : (exc_eret ? epc_q : HANDLER);

endmodule

// File: tb/tb_cp0_irq.sv
// Bench for cp0_irq: register-map table plus hand sequences for interrupts, timer, exceptions.
module tb_cp0_irq;

   logic        clk = 1'b0;
   logic        reset, we, pipe_busy, exc_valid, exc_eret, exc_bd;
   logic [4:0]  num, exc_code, ext_irq;
   logic [31:0] wdata, rdata, exc_pc, exc_badvaddr, jump_addr;
   logic        jump, irq_now;

   always #5 clk = ~clk;

   cp0_irq #(
      .NUM_IRQ   (5),
      .IRQ_EDGE  (5'b00001),
      .COUNT_DIV (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .we           (we),
      .num          (num),
      .wdata        (wdata),
      .rdata        (rdata),
      .pipe_busy    (pipe_busy),
      .exc_valid    (exc_valid),
      .exc_eret     (exc_eret),
      .exc_code     (exc_code),
      .exc_pc       (exc_pc),
      .exc_bd       (exc_bd),
      .exc_badvaddr (exc_badvaddr),
      .jump         (jump),
      .jump_addr    (jump_addr),
      .irq_now      (irq_now),
      .ext_irq      (ext_irq)
   );

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   typedef struct {
      bit          do_wr;
      logic [4:0]  wnum;
      logic [31:0] wval;
      logic [4:0]  rnum;
      logic [31:0] exp;
      string       name;
   } vec_t;

   sb_t  sbq[$];
   vec_t vt[12];
   int   total = 0;
   int   bad   = 0;

   task automatic push_exp(input string n, input logic [31:0] e);
      sb_t s;
      s.name = n;
      s.exp  = e;
      sbq.push_back(s);
   endtask

   task automatic pop_cmp(input logic [31:0] act);
      sb_t s;
      total++;
      if (sbq.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty got=%h", act);
         return;
      end
      s = sbq.pop_front();
      if (act !== s.exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", s.name, act, s.exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] n, input logic [31:0] d);
      we = 1'b1;
      num = n;
      wdata = d;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [4:0] n, input logic [31:0] e);
      num = n;
      push_exp(nm, e);
      @(negedge clk);
      pop_cmp(rdata);
   endtask

   task automatic chk_irq(input string nm, input logic e);
      push_exp(nm, {31'b0, e});
      @(negedge clk);
      pop_cmp({31'b0, irq_now});
   endtask

   task automatic chk_jump(input string nm, input logic ej, input logic [31:0] ea);
      push_exp({nm, "_jump"}, {31'b0, ej});
      push_exp({nm, "_addr"}, ea);
      #1;
      pop_cmp({31'b0, jump});
      pop_cmp(jump_addr);
   endtask

   task automatic drive_exc(input logic eret, input logic [31:0] pc, input logic bd,
                            input logic [4:0] code, input logic [31:0] bva);
      exc_valid = 1'b1;
      exc_eret = eret;
      exc_pc = pc;
      exc_bd = bd;
      exc_code = code;
      exc_badvaddr = bva;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1'b0, 5'd0,  32'h0,        5'd12, 32'h0000FF02, "rst_sr"};
      vt[1]  = '{1'b0, 5'd0,  32'h0,        5'd13, 32'h0,        "rst_cause"};
      vt[2]  = '{1'b0, 5'd0,  32'h0,        5'd15, 32'hDEADBEEF, "rst_prid"};
      vt[3]  = '{1'b0, 5'd0,  32'h0,        5'd3,  32'h0,        "rst_unimpl"};
      vt[4]  = '{1'b0, 5'd0,  32'h0,        5'd14, 32'h0,        "rst_epc"};
      vt[5]  = '{1'b1, 5'd3,  32'hFFFFFFFF, 5'd3,  32'h0,        "unimpl_wr"};
      vt[6]  = '{1'b1, 5'd15, 32'h0,        5'd15, 32'hDEADBEEF, "prid_ro"};
      vt[7]  = '{1'b1, 5'd12, 32'hFFFFFFFF, 5'd12, 32'h0000FF03, "sr_mask"};
      vt[8]  = '{1'b1, 5'd12, 32'h0000A501, 5'd12, 32'h0000A501, "sr_wr"};
      vt[9]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 32'h00000300, "cause_mask"};
      vt[10] = '{1'b1, 5'd13, 32'h0,        5'd13, 32'h0,        "cause_clr"};
      vt[11] = '{1'b1, 5'd14, 32'h12345678, 5'd14, 32'h12345678, "epc_wr"};

      reset = 1'b1; we = 1'b0; num = '0; wdata = '0; pipe_busy = 1'b0;
      exc_valid = 1'b0; exc_eret = 1'b0; exc_code = '0; exc_pc = '0;
      exc_bd = 1'b0; exc_badvaddr = '0; ext_irq = '0;
      step();
      step();
      reset = 1'b0;
      chk_irq("rst_irq", 1'b0);
      chk_jump("rst_nojump", 1'b0, 32'h0);

      for (int i = 0; i < 12; i++) begin
         if (vt[i].do_wr) wr(vt[i].wnum, vt[i].wval);
         rd(vt[i].name, vt[i].rnum, vt[i].exp);
      end

      // Software interrupts, masking and pipe_busy
      wr(5'd12, 32'h0000FF01);
      wr(5'd13, 32'h00000200);
      chk_irq("irq_sw", 1'b1);
      pipe_busy = 1'b1;
      chk_irq("irq_busy", 1'b0);
      pipe_busy = 1'b0;
      wr(5'd12, 32'h0000FD01);
      chk_irq("irq_masked", 1'b0);
      wr(5'd12, 32'h0000FF01);
      wr(5'd13, 32'h0);
      chk_irq("irq_sw_clr", 1'b0);

      // Edge line 0: pulse latches, Cause write of 0 clears
      ext_irq = 5'b00001;
      step();
      ext_irq = 5'b00000;
      step();
      step();
      rd("edge_hold", 5'd13, 32'h00000400);
      chk_irq("irq_edge", 1'b1);
      wr(5'd13, 32'h0);
      rd("edge_clr", 5'd13, 32'h0);

      // New edge in the same cycle as a clear: set wins
      ext_irq = 5'b00001;
      step();
      ext_irq = 5'b00000;
      step();
      ext_irq = 5'b00001;
      wr(5'd13, 32'h0);
      ext_irq = 5'b00000;
      rd("edge_set_wins", 5'd13, 32'h00000400);
      wr(5'd13, 32'h0);
      rd("edge_clr2", 5'd13, 32'h0);

      // Level line 1 follows irq_q
      ext_irq = 5'b00010;
      step();
      rd("level_on", 5'd13, 32'h00000800);
      chk_irq("irq_level", 1'b1);
      ext_irq = 5'b00000;
      step();
      rd("level_off", 5'd13, 32'h0);

`ifdef CP0_TIMER_EN
      wr(5'd11, 32'd8);
      wr(5'd9, 32'd0);
      repeat (31) step();
      rd("count_7", 5'd9, 32'd7);
      step();
      rd("timer_ip", 5'd13, 32'h00008000);
      chk_irq("irq_timer", 1'b1);
      wr(5'd11, 32'd100);
      rd("timer_clr", 5'd13, 32'h0);
      wr(5'd11, 32'd0);
`else
      wr(5'd9, 32'd5);
      rd("count_off", 5'd9, 32'h0);
      wr(5'd11, 32'd7);
      rd("compare_off", 5'd11, 32'h0);
`endif

      // Exception in a delay slot with address error
      drive_exc(1'b0, 32'h00400010, 1'b1, 5'd4, 32'h00001233);
      chk_jump("exc1", 1'b1, 32'hBFC00380);
      step();
      exc_valid = 1'b0;
      chk_jump("exc1_idle", 1'b0, 32'h0);
      rd("exc1_epc", 5'd14, 32'h0040000C);
      rd("exc1_cause", 5'd13, 32'h80000010);
      rd("exc1_bva", 5'd8, 32'h00001233);
      rd("exc1_sr", 5'd12, 32'h0000FF03);

      // Nested exception while EXL=1 changes nothing
      drive_exc(1'b0, 32'h00500000, 1'b0, 5'd5, 32'h00009999);
      chk_jump("exc2", 1'b1, 32'hBFC00380);
      step();
      exc_valid = 1'b0;
      rd("exc2_epc", 5'd14, 32'h0040000C);
      rd("exc2_bva", 5'd8, 32'h00001233);
      rd("exc2_cause", 5'd13, 32'h80000010);

      // ERET returns to EPC and clears EXL
      drive_exc(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
      chk_jump("eret", 1'b1, 32'h0040000C);
      step();
      exc_valid = 1'b0;
      exc_eret = 1'b0;
      rd("eret_sr", 5'd12, 32'h0000FF01);

      // mtc0 to EPC in the same cycle as an exception is discarded
      drive_exc(1'b0, 32'h00600000, 1'b0, 5'd0, 32'h0000FFFF);
      we = 1'b1;
      num = 5'd14;
      wdata = 32'h00001234;
      chk_jump("exc3", 1'b1, 32'hBFC00380);
      step();
      we = 1'b0;
      exc_valid = 1'b0;
      rd("exc3_epc", 5'd14, 32'h00600000);
      rd("exc3_bva", 5'd8, 32'h00001233);
      rd("exc3_cause", 5'd13, 32'h0);
      rd("exc3_sr", 5'd12, 32'h0000FF03);

      // Reset mid-operation
      wr(5'd13, 32'h00000100);
      reset = 1'b1;
      step();
      reset = 1'b0;
      rd("mid_rst_sr", 5'd12, 32'h0000FF02);
      rd("mid_rst_cause", 5'd13, 32'h0);
      rd("mid_rst_epc", 5'd14, 32'h0);
      rd("mid_rst_bva", 5'd8, 32'h0);

      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
